// File: rtl/cpu_dump_pkg.sv
// Shared types and sizing helpers for the CPU state dump block.
package cpu_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_REG,
    ST_MEM,
    ST_STOP
  } dump_state_e;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;

  function automatic int mem_words(input int mem_bytes);
    return mem_bytes / 4;
  endfunction

  function automatic int frame_beats(input int num_regs, input int mem_bytes);
    return 1 + num_regs + mem_bytes / 4;
  endfunction

endpackage

// File: rtl/cpu_dump_cycle_ctr.sv
// Saturating CPU cycle counter with a phase register that flags multiples of PERIOD.
module cpu_dump_cycle_ctr
#(
  parameter int PERIOD = 1
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        en,
  input  logic        clr,
  output logic [31:0] cnt,
  output logic        tick
);

  localparam logic [31:0] PHASE_LAST = 32'(PERIOD - 1);

  // phase tracks cnt mod PERIOD without a divider
  logic [31:0] phase;

  always_ff @(posedge clk) begin
    if (!rst_b || clr) begin
      cnt   <= '0;
      phase <= '0;
    end else if (en && (cnt != '1)) begin
      cnt   <= cnt + 32'd1;
      phase <= (phase == PHASE_LAST) ? '0 : phase + 32'd1;
    end
  end

  assign tick = (cnt != '0) && (phase == '0);

endmodule

// File: rtl/cpu_state_dump.sv
// Counts CPU cycles and streams register-file / data-memory snapshot frames
// over valid/ready while holding the CPU.
module cpu_state_dump
  import cpu_dump_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int MEM_BYTES  = 128,
  parameter int PERIOD     = 1,
  parameter int RUN_CYCLES = 20
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        periodic_i,
  output logic        cpu_hold_o,
  output logic [4:0]  rf_addr_o,
  input  logic [31:0] rf_data_i,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_data_i,
  output logic        dump_valid_o,
  input  logic        dump_ready_i,
  output logic [31:0] dump_data_o,
  output logic        dump_last_o,
  output logic [31:0] cycle_cnt_o,
  output logic        stop_o
);

  // state | meaning
  // IDLE  | CPU runs, cycle counter advances, waiting for a trigger
  // HDR   | header beat {A5, frame_no, cycle_cnt[15:0]}
  // REG   | register-file beats, rf_addr_o = index
  // MEM   | data-memory beats, mem_addr_o = 4 * index
  // STOP  | run limit reached and final frame sent; CPU held until reset

  localparam int          MEM_WORDS = mem_words(MEM_BYTES);
  localparam logic [29:0] REG_LAST  = 30'(NUM_REGS - 1);
  localparam logic [29:0] MEM_LAST  = 30'(MEM_WORDS - 1);
  localparam logic [31:0] RUN_LIMIT = 32'(RUN_CYCLES);

  dump_state_e state;
  logic [29:0] idx;
  logic [7:0]  frame_no;
  logic        final_frame;
  logic        dumped;
  logic [31:0] cycle_cnt;
  logic        period_hit;
  logic        in_idle;
  logic        at_limit;
  logic        tick;
  logic        trigger;
  logic        cnt_en;
  logic        xfer;

  cpu_dump_cycle_ctr #(.PERIOD(PERIOD)) u_cycle_ctr (
    .clk   (clk_i),
    .rst_b (rst_i),
    .en    (cnt_en),
    .clr   (1'b0),
    .cnt   (cycle_cnt),
    .tick  (period_hit)
  );

  // dumped blocks a second periodic frame at a count value already dumped
  assign in_idle  = (state == ST_IDLE);
  assign at_limit = (RUN_CYCLES != 0) && (cycle_cnt == RUN_LIMIT);
  assign tick     = periodic_i && period_hit && !dumped;
  assign trigger  = rst_i && in_idle && (start_i || tick || at_limit);
  assign cnt_en   = in_idle && !trigger;

  assign dump_valid_o = (state == ST_HDR) || (state == ST_REG) || (state == ST_MEM);
  assign xfer         = dump_valid_o && dump_ready_i;
  assign cpu_hold_o   = trigger || !in_idle;
  assign stop_o       = (state == ST_STOP);
  assign cycle_cnt_o  = cycle_cnt;
  assign rf_addr_o    = (state == ST_REG) ? idx[4:0] : '0;
  assign mem_addr_o   = (state == ST_MEM) ? {idx, 2'b00} : '0;
  assign dump_last_o  = (state == ST_MEM) && (idx == MEM_LAST);

  always_comb begin
    dump_data_o = '0;
    case (state)
      ST_HDR:  dump_data_o = {HDR_MAGIC, frame_no, cycle_cnt[15:0]};
      ST_REG:  dump_data_o = rf_data_i;
      ST_MEM:  dump_data_o = mem_data_i;
      default: dump_data_o = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= ST_IDLE;
      idx         <= '0;
      frame_no    <= '0;
      final_frame <= 1'b0;
      dumped      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            state       <= ST_HDR;
            final_frame <= at_limit;
            dumped      <= 1'b1;
          end else begin
            dumped <= 1'b0;
          end
        end
        ST_HDR: begin
          if (xfer) begin
            state <= ST_REG;
            idx   <= '0;
          end
        end
        ST_REG: begin
          if (xfer) begin
            if (idx == REG_LAST) begin
              state <= ST_MEM;
              idx   <= '0;
            end else begin
              idx <= idx + 30'd1;
            end
          end
        end
        ST_MEM: begin
          if (xfer) begin
            if (idx == MEM_LAST) begin
              idx      <= '0;
              frame_no <= frame_no + 8'd1;
              state    <= final_frame ? ST_STOP : ST_IDLE;
            end else begin
              idx <= idx + 30'd1;
            end
          end
        end
        ST_STOP: state <= ST_STOP;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_state_dump.sv
// Bench for cpu_state_dump: two instances (run-limited PERIOD=1, unlimited PERIOD=4)
// checked every cycle against a beat-position model plus literal expectations.
module tb_cpu_state_dump;

  localparam int NR = 32;
  localparam int MB = 32;   // 32-byte DM window gives a 1 + 32 + 8 = 41-beat frame
  localparam int MW = MB / 4;
  localparam int FB = 1 + NR + MW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b0, start_a = 1'b0, periodic_a = 1'b0, ready_a = 1'b0;
  logic        hold_a, valid_a, last_a, stop_a;
  logic [4:0]  rf_addr_a;
  logic [31:0] mem_addr_a, data_a, cnt_a, rf_data_a, mem_data_a;

  logic        rst_b = 1'b0, start_b = 1'b0, periodic_b = 1'b0, ready_b = 1'b0;
  logic        hold_b, valid_b, last_b, stop_b;
  logic [4:0]  rf_addr_b;
  logic [31:0] mem_addr_b, data_b, cnt_b, rf_data_b, mem_data_b;

  logic [31:0] rf_mem [NR];
  logic [31:0] dm [MW];

  initial begin
    for (int i = 0; i < NR; i++) rf_mem[i] = (i < 4) ? 32'(i) : 32'h1000 + 32'(i);
    for (int i = 0; i < MW; i++) dm[i] = 32'hC0DE_0000 + 32'(i);
    dm[0] = 32'h0403_0201;
  end

  function automatic logic [31:0] rd_dm(input logic [31:0] a);
    int w;
    w = int'(a >> 2);
    return (w >= 0 && w < MW) ? dm[w] : 32'hDEAD_BEEF;
  endfunction

  assign rf_data_a  = rf_mem[rf_addr_a];
  assign mem_data_a = rd_dm(mem_addr_a);
  assign rf_data_b  = rf_mem[rf_addr_b];
  assign mem_data_b = rd_dm(mem_addr_b);

  cpu_state_dump #(.NUM_REGS(NR), .MEM_BYTES(MB), .PERIOD(1), .RUN_CYCLES(20)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .start_i(start_a), .periodic_i(periodic_a),
    .cpu_hold_o(hold_a), .rf_addr_o(rf_addr_a), .rf_data_i(rf_data_a),
    .mem_addr_o(mem_addr_a), .mem_data_i(mem_data_a), .dump_valid_o(valid_a),
    .dump_ready_i(ready_a), .dump_data_o(data_a), .dump_last_o(last_a),
    .cycle_cnt_o(cnt_a), .stop_o(stop_a)
  );

  cpu_state_dump #(.NUM_REGS(NR), .MEM_BYTES(MB), .PERIOD(4), .RUN_CYCLES(0)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .start_i(start_b), .periodic_i(periodic_b),
    .cpu_hold_o(hold_b), .rf_addr_o(rf_addr_b), .rf_data_i(rf_data_b),
    .mem_addr_o(mem_addr_b), .mem_data_i(mem_data_b), .dump_valid_o(valid_b),
    .dump_ready_i(ready_b), .dump_data_o(data_b), .dump_last_o(last_b),
    .cycle_cnt_o(cnt_b), .stop_o(stop_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: cycle count, frame number, and position within the 41-beat frame
  int m_cnt [2] = '{0, 0};
  int m_fno [2] = '{0, 0};
  int m_pos [2] = '{0, 0};
  int m_seen[2] = '{-1, -1};
  bit m_busy[2] = '{0, 0};
  bit m_stop[2] = '{0, 0};
  bit m_fin [2] = '{0, 0};

  int nbeat [2] = '{0, 0};
  int nframe[2] = '{0, 0};
  logic [31:0] beats_a[$];
  logic [31:0] hdr_b[$];

  task automatic step(input int d, input string p,
                      input logic rst, input logic start, input logic periodic, input logic ready,
                      input logic hold, input logic valid, input logic last, input logic stop,
                      input logic [4:0] rf_addr, input logic [31:0] mem_addr,
                      input logic [31:0] data, input logic [31:0] cnt);
    int run, per;
    bit due, trig, regs, mems;
    logic [31:0] want;
    run  = (d == 0) ? 20 : 0;
    per  = (d == 0) ? 1 : 4;
    due  = periodic && m_cnt[d] != 0 && (m_cnt[d] % per) == 0 && m_cnt[d] != m_seen[d];
    trig = rst && !m_busy[d] && !m_stop[d] && (start || due || (run != 0 && m_cnt[d] == run));
    regs = m_busy[d] && m_pos[d] >= 1 && m_pos[d] <= NR;
    mems = m_busy[d] && m_pos[d] > NR;
    if (!m_busy[d])       want = '0;
    else if (m_pos[d] == 0) want = {8'hA5, 8'(m_fno[d]), 16'(m_cnt[d])};
    else if (regs)        want = rf_mem[m_pos[d] - 1];
    else                  want = dm[m_pos[d] - 1 - NR];

    chk({p, "hold"},      32'(hold),  32'(m_busy[d] || m_stop[d] || trig));
    chk({p, "valid"},     32'(valid), 32'(m_busy[d]));
    chk({p, "data"},      data,       want);
    chk({p, "last"},      32'(last),  32'(m_busy[d] && m_pos[d] == FB - 1));
    chk({p, "rf_addr"},   32'(rf_addr), regs ? 32'(m_pos[d] - 1) : 32'd0);
    chk({p, "mem_addr"},  mem_addr,   mems ? 32'(4 * (m_pos[d] - 1 - NR)) : 32'd0);
    chk({p, "cycle_cnt"}, cnt,        32'(m_cnt[d]));
    chk({p, "stop"},      32'(stop),  32'(m_stop[d]));

    if (!rst) begin
      nbeat[d] = 0;
    end else if (valid && ready) begin
      if (d == 0) beats_a.push_back(data);
      else if (nbeat[d] == 0) hdr_b.push_back(data);
      if (last) begin
        chk({p, "frame_len"}, 32'(nbeat[d] + 1), 32'(FB));
        nbeat[d] = 0;
        nframe[d]++;
      end else begin
        nbeat[d]++;
      end
    end

    if (!rst) begin
      m_cnt[d] = 0; m_fno[d] = 0; m_pos[d] = 0; m_seen[d] = -1;
      m_busy[d] = 0; m_stop[d] = 0; m_fin[d] = 0;
    end else if (m_busy[d]) begin
      if (ready) begin
        if (m_pos[d] == FB - 1) begin
          m_busy[d] = 0;
          m_fno[d]  = (m_fno[d] + 1) % 256;
          m_stop[d] = m_fin[d];
        end else begin
          m_pos[d]++;
        end
      end
    end else if (!m_stop[d]) begin
      if (trig) begin
        m_busy[d] = 1;
        m_pos[d]  = 0;
        m_fin[d]  = (run != 0 && m_cnt[d] == run);
        m_seen[d] = m_cnt[d];
      end else begin
        m_cnt[d]++;
      end
    end
  endtask

  always @(negedge clk) begin
    step(0, "a_", rst_a, start_a, periodic_a, ready_a, hold_a, valid_a, last_a, stop_a,
         rf_addr_a, mem_addr_a, data_a, cnt_a);
    step(1, "b_", rst_b, start_b, periodic_b, ready_b, hold_b, valid_b, last_b, stop_b,
         rf_addr_b, mem_addr_b, data_b, cnt_b);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    fork
      begin : run_a
        int n, base, fbase;
        periodic_a = 1'b1;
        ready_a    = 1'b1;
        repeat (3) cyc();
        rst_a = 1'b1;
        base  = beats_a.size();
        fbase = nframe[0];

        // backpressure at beat 5 of frame 1
        for (n = 0; n < 400 && !(nframe[0] == fbase + 1 && nbeat[0] == 5); n++) cyc();
        chk("bp_reach", 32'(n < 400), 32'd1);
        ready_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
          #2;
          chk("bp_valid",   32'(valid_a),   32'd1);
          chk("bp_rf_addr", 32'(rf_addr_a), 32'd4);
          chk("bp_data",    data_a,         32'h0000_1004);
          chk("bp_hold",    32'(hold_a),    32'd1);
          chk("bp_cnt",     cnt_a,          32'd2);
          cyc();
        end
        ready_a = 1'b1;

        for (n = 0; n < 3000 && !stop_a; n++) cyc();
        chk("stop_reach",  32'(n < 3000), 32'd1);
        chk("frames_run",  32'(nframe[0] - fbase), 32'd20);
        chk("final_cnt",   cnt_a, 32'd20);
        chk("hdr_frame0",  beats_a[base], 32'hA500_0001);
        chk("beat2_r1",    beats_a[base + 2], 32'd1);
        chk("beat3_r2",    beats_a[base + 3], 32'd2);
        chk("beat4_r3",    beats_a[base + 4], 32'd3);
        chk("mem_beat0",   beats_a[base + 1 + NR], 32'h0403_0201);
        chk("hdr_frame19", beats_a[base + 19 * FB], 32'hA513_0014);

        start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        cyc();
        chk("stop_valid", 32'(valid_a), 32'd0);
        chk("stop_hold",  32'(hold_a),  32'd1);

        // single-shot at cycle 7, second start mid-frame ignored
        rst_a      = 1'b0;
        periodic_a = 1'b0;
        repeat (2) cyc();
        rst_a = 1'b1;
        base  = beats_a.size();
        fbase = nframe[0];
        for (n = 0; n < 50 && cnt_a != 32'd7; n++) cyc();
        chk("ss_reach7", 32'(n < 50), 32'd1);
        start_a = 1'b1;
        #1;
        chk("ss_hold_comb", 32'(hold_a), 32'd1);
        cyc();
        start_a = 1'b0;
        for (n = 0; n < 100 && nbeat[0] != 20; n++) cyc();
        start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        for (n = 0; n < 100 && nframe[0] == fbase; n++) cyc();
        chk("ss_done", 32'(n < 100), 32'd1);
        repeat (4) cyc();
        chk("ss_frames", 32'(nframe[0] - fbase), 32'd1);
        chk("ss_hdr_lo", beats_a[base] & 32'h0000_FFFF, 32'h0000_0007);
        chk("ss_hdr",    beats_a[base], 32'hA500_0007);

        // reset in the middle of a frame
        rst_a      = 1'b0;
        periodic_a = 1'b1;
        repeat (2) cyc();
        rst_a = 1'b1;
        fbase = nframe[0];
        for (n = 0; n < 100 && nbeat[0] != 10; n++) cyc();
        chk("rst_reach", 32'(n < 100), 32'd1);
        rst_a = 1'b0;
        cyc();
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_hold",  32'(hold_a),  32'd0);
        chk("rst_last",  32'(last_a),  32'd0);
        rst_a = 1'b1;
        base  = beats_a.size();
        for (n = 0; n < 20 && beats_a.size() == base; n++) cyc();
        chk("rst_restart", 32'(n < 20), 32'd1);
        chk("rst_hdr",     beats_a[base], 32'hA500_0001);
        chk("rst_frames",  32'(nframe[0] - fbase), 32'd0);
      end
      begin : run_b
        int n;
        periodic_b = 1'b1;
        ready_b    = 1'b1;
        repeat (3) cyc();
        rst_b = 1'b1;
        for (n = 0; n < 13000 && nframe[1] < 258; n++) cyc();
        chk("b_reach",   32'(n < 13000), 32'd1);
        chk("b_hdr0",    hdr_b[0],   32'hA500_0004);
        chk("b_hdr1",    hdr_b[1],   32'hA501_0008);
        chk("b_hdr2",    hdr_b[2],   32'hA502_000C);
        chk("b_hdr255",  hdr_b[255], 32'hA5FF_0400);
        chk("b_hdr256",  hdr_b[256], 32'hA500_0404);
        chk("b_nostop",  32'(stop_b), 32'd0);
      end
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
